// File: rtl/cache_assoc.sv
// cache_assoc
// Set-associative, write-back, write-allocate cache between a CPU word
// port and a 128-bit memory arbiter. Each block is 16 words held as four
// 128-bit beats. Victims are chosen as the lowest invalid way, otherwise
// the set's round-robin pointer. A dirty victim is written back in full
// before the refill, and the request is then replayed as a hit.
//
// Ports
//   clk, reset            : clock, asynchronous active-high reset
//   cpu_req_valid/ready   : request handshake
//   cpu_req_addr          : word address {tag, index, offset[3:0]}
//   cpu_req_data/write    : store data and byte mask (mask 0 = load)
//   cpu_resp_valid/data   : one-cycle load response, data held afterwards
//   mem_req_valid/ready   : memory command handshake
//   mem_req_addr/rw       : beat address, 1 = write
//   mem_req_data_*        : write-back beat data, handshake and byte mask
//   mem_resp_valid/data   : refill beats
//   hit_count/miss_count  : saturating lookup counters, only when
//                           CACHE_PERF_CNT_EN is defined
module cache_assoc #(
    parameter int LINES          = 64,
    parameter int WAYS           = 2,
    parameter int CPU_WIDTH      = 32,
    parameter int WORD_ADDR_BITS = 30
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cpu_req_valid,
    output logic                      cpu_req_ready,
    input  logic [WORD_ADDR_BITS-1:0] cpu_req_addr,
    input  logic [CPU_WIDTH-1:0]      cpu_req_data,
    input  logic [3:0]                cpu_req_write,
    output logic                      cpu_resp_valid,
    output logic [CPU_WIDTH-1:0]      cpu_resp_data,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic [WORD_ADDR_BITS-3:0] mem_req_addr,
    output logic                      mem_req_rw,
    output logic                      mem_req_data_valid,
    input  logic                      mem_req_data_ready,
    output logic [127:0]              mem_req_data_bits,
    output logic [15:0]               mem_req_data_mask,
    input  logic                      mem_resp_valid,
    input  logic [127:0]              mem_resp_data
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [31:0]               hit_count,
    output logic [31:0]               miss_count
`endif
);

    localparam int IDX_BITS = $clog2(LINES);
    localparam int TAG_BITS = WORD_ADDR_BITS - 4 - IDX_BITS;
    localparam int WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int RAM_BITS = IDX_BITS + 2;

    typedef enum logic [2:0] {IDLE, LOOKUP, RESP, WB, FILL_REQ, FILL} state_t;

    state_t state, next_state;

    logic [WORD_ADDR_BITS-1:0]          req_addr_q;
    logic [CPU_WIDTH-1:0]               req_data_q;
    logic [3:0]                         req_mask_q;
    logic [CPU_WIDTH-1:0]               resp_data_q;
    logic [WAY_BITS-1:0]                victim_q;
    logic [TAG_BITS-1:0]                victim_tag_q;
    logic [1:0]                         wb_beat;
    logic                               wb_ok;
    logic [1:0]                         fill_beat;
    logic [LINES-1:0][WAYS-1:0]         valid_q;
    logic [LINES-1:0][WAYS-1:0]         dirty_q;
    logic [LINES-1:0][WAY_BITS-1:0]     victim_ptr_q;

    logic [TAG_BITS-1:0]  req_tag;
    logic [IDX_BITS-1:0]  req_idx;
    logic [1:0]           req_beat;
    logic [1:0]           req_word;
    logic                 is_store;
    logic [IDX_BITS-1:0]  rd_idx;
    logic [RAM_BITS-1:0]  ram_raddr;

    logic [127:0]         data_rd [WAYS];
    logic [TAG_BITS-1:0]  tag_rd  [WAYS];
    logic [WAYS-1:0]      data_we;
    logic [RAM_BITS-1:0]  data_waddr;
    logic [127:0]         data_wdata;
    logic [15:0]          data_wmask;
    logic [WAYS-1:0]      tag_we;

    logic                 hit;
    logic [WAY_BITS-1:0]  hit_way;
    logic                 found;
    logic [WAY_BITS-1:0]  victim;
    logic [CPU_WIDTH-1:0] hit_data;

    assign req_tag  = req_addr_q[WORD_ADDR_BITS-1 -: TAG_BITS];
    assign req_idx  = req_addr_q[4 +: IDX_BITS];
    assign req_beat = req_addr_q[3:2];
    assign req_word = req_addr_q[1:0];
    assign is_store = |req_mask_q;

    // The arrays read one cycle ahead: in IDLE the incoming address is
    // presented so LOOKUP sees its set, during write-back the beat being
    // sent is read, and otherwise the registered request is re-read.
    assign rd_idx    = (state == IDLE) ? cpu_req_addr[4 +: IDX_BITS] : req_idx;
    assign ram_raddr = (state == WB)   ? {req_idx, wb_beat}
                     : (state == IDLE) ? {rd_idx, cpu_req_addr[3:2]}
                     :                   {req_idx, req_beat};

    // Per-way data and tag storage with a registered read. A write to the
    // address being read is forwarded into the read register, so the
    // replay lookup straight after the last refill beat sees the new line.
    for (genvar w = 0; w < WAYS; w++) begin : g_way
        logic [127:0]        data_mem [LINES*4];
        logic [TAG_BITS-1:0] tag_mem  [LINES];
        logic [127:0]        rd_q;
        logic [TAG_BITS-1:0] tag_q;

        always_ff @(posedge clk) begin
            for (int b = 0; b < 16; b++) begin
                if (data_we[w] && data_wmask[b]) begin
                    data_mem[data_waddr][b*8 +: 8] <= data_wdata[b*8 +: 8];
                end
                if (data_we[w] && data_wmask[b] && (data_waddr == ram_raddr)) begin
                    rd_q[b*8 +: 8] <= data_wdata[b*8 +: 8];
                end else begin
                    rd_q[b*8 +: 8] <= data_mem[ram_raddr][b*8 +: 8];
                end
            end
            if (tag_we[w]) begin
                tag_mem[req_idx] <= req_tag;
            end
            tag_q <= (tag_we[w] && (req_idx == rd_idx)) ? req_tag : tag_mem[rd_idx];
        end

        assign data_rd[w] = rd_q;
        assign tag_rd[w]  = tag_q;
    end

    // Way comparison and victim choice: the lowest invalid way wins,
    // otherwise the set's round-robin pointer names the victim.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        found   = 1'b0;
        victim  = victim_ptr_q[req_idx];
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && valid_q[req_idx][w] && (tag_rd[w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_BITS'(w);
            end
            if (!found && !valid_q[req_idx][w]) begin
                found  = 1'b1;
                victim = WAY_BITS'(w);
            end
        end
        hit_data = data_rd[hit_way][req_word*CPU_WIDTH +: CPU_WIDTH];
    end

    // State register; reset mid-transaction abandons whatever was under way.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state, handshake outputs and array write controls. Memory
    // outputs depend only on state and registers, never on mem_req_ready.
    always_comb begin
        next_state         = state;
        cpu_req_ready      = 1'b0;
        cpu_resp_valid     = 1'b0;
        mem_req_valid      = 1'b0;
        mem_req_rw         = 1'b0;
        mem_req_addr       = '0;
        mem_req_data_valid = 1'b0;
        mem_req_data_bits  = '0;
        mem_req_data_mask  = '0;
        data_we            = '0;
        data_waddr         = {req_idx, req_beat};
        data_wdata         = {(128/CPU_WIDTH){req_data_q}};
        data_wmask         = '0;
        tag_we             = '0;
        case (state)
            IDLE: begin
                cpu_req_ready = 1'b1;
                if (cpu_req_valid) begin
                    next_state = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    if (is_store) begin
                        data_we[hit_way] = 1'b1;
                        data_wmask       = 16'(req_mask_q) << {req_word, 2'b00};
                        next_state       = IDLE;
                    end else begin
                        next_state = RESP;
                    end
                end else if (valid_q[req_idx][victim] && dirty_q[req_idx][victim]) begin
                    next_state = WB;
                end else begin
                    next_state = FILL_REQ;
                end
            end
            RESP: begin
                cpu_resp_valid = 1'b1;
                next_state     = IDLE;
            end
            WB: begin
                mem_req_rw   = 1'b1;
                mem_req_addr = {victim_tag_q, req_idx, wb_beat};
                if (wb_ok) begin
                    mem_req_valid      = 1'b1;
                    mem_req_data_valid = 1'b1;
                    mem_req_data_bits  = data_rd[victim_q];
                    mem_req_data_mask  = 16'hFFFF;
                    if (mem_req_ready && mem_req_data_ready && (wb_beat == 2'd3)) begin
                        next_state = FILL_REQ;
                    end
                end
            end
            FILL_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {req_tag, req_idx, 2'b00};
                if (mem_req_ready) begin
                    next_state = FILL;
                end
            end
            FILL: begin
                if (mem_resp_valid) begin
                    data_we[victim_q] = 1'b1;
                    data_waddr        = {req_idx, fill_beat};
                    data_wdata        = mem_resp_data;
                    data_wmask        = 16'hFFFF;
                    if (fill_beat == 2'd3) begin
                        tag_we[victim_q] = 1'b1;
                        next_state       = LOOKUP;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Request capture, line state bits and beat counters. A write-back beat
    // only goes out once its data has come through the read register
    // (wb_ok), and is then held until both memory readies are seen together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_addr_q   <= '0;
            req_data_q   <= '0;
            req_mask_q   <= '0;
            resp_data_q  <= '0;
            victim_q     <= '0;
            victim_tag_q <= '0;
            wb_beat      <= '0;
            wb_ok        <= 1'b0;
            fill_beat    <= '0;
            valid_q      <= '0;
            dirty_q      <= '0;
            victim_ptr_q <= '0;
        end else begin
            if ((state == IDLE) && cpu_req_valid) begin
                req_addr_q <= cpu_req_addr;
                req_data_q <= cpu_req_data;
                req_mask_q <= cpu_req_write;
            end
            if (state == LOOKUP) begin
                if (hit) begin
                    if (is_store) begin
                        dirty_q[req_idx][hit_way] <= 1'b1;
                    end else begin
                        resp_data_q <= hit_data;
                    end
                end else begin
                    victim_q     <= victim;
                    victim_tag_q <= tag_rd[victim];
                    wb_beat      <= '0;
                    wb_ok        <= 1'b0;
                    fill_beat    <= '0;
                end
            end
            if (state == WB) begin
                if (!wb_ok) begin
                    wb_ok <= 1'b1;
                end else if (mem_req_ready && mem_req_data_ready) begin
                    wb_beat <= wb_beat + 1'b1;
                    wb_ok   <= 1'b0;
                end
            end
            if ((state == FILL) && mem_resp_valid) begin
                fill_beat <= fill_beat + 1'b1;
                if (fill_beat == 2'd3) begin
                    valid_q[req_idx][victim_q] <= 1'b1;
                    dirty_q[req_idx][victim_q] <= 1'b0;
                    victim_ptr_q[req_idx]      <= (WAYS == 1) ? '0 : victim_ptr_q[req_idx] + 1'b1;
                end
            end
        end
    end

    assign cpu_resp_data = resp_data_q;

`ifdef CACHE_PERF_CNT_EN
    logic replay_q;

    // Lookup counters. The lookup that follows a refill is a replay of an
    // already-counted miss, so it is flagged and skipped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
            replay_q   <= 1'b0;
        end else begin
            if ((state == FILL) && mem_resp_valid && (fill_beat == 2'd3)) begin
                replay_q <= 1'b1;
            end else if (state == LOOKUP) begin
                replay_q <= 1'b0;
            end
            if ((state == LOOKUP) && !replay_q) begin
                if (hit) begin
                    if (hit_count != 32'hFFFF_FFFF) begin
                        hit_count <= hit_count + 1'b1;
                    end
                end else if (miss_count != 32'hFFFF_FFFF) begin
                    miss_count <= miss_count + 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_assoc.sv
// tb_cache_assoc
// Directed bench for cache_assoc with default parameters (64 sets, 2 ways).
// A behavioural memory answers refills with word value = word address
// unless a write-back has overwritten that word, and logs every memory
// transaction so the directed steps can check traffic against hand values.
module tb_cache_assoc;

    logic         clk = 1'b0;
    logic         reset;
    logic         cpu_req_valid;
    logic         cpu_req_ready;
    logic [29:0]  cpu_req_addr;
    logic [31:0]  cpu_req_data;
    logic [3:0]   cpu_req_write;
    logic         cpu_resp_valid;
    logic [31:0]  cpu_resp_data;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic [27:0]  mem_req_addr;
    logic         mem_req_rw;
    logic         mem_req_data_valid;
    logic         mem_req_data_ready;
    logic [127:0] mem_req_data_bits;
    logic [15:0]  mem_req_data_mask;
    logic         mem_resp_valid;
    logic [127:0] mem_resp_data;
`ifdef CACHE_PERF_CNT_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0]  mem_store [int unsigned];
    logic [27:0]  rd_log [$];
    logic [27:0]  wr_addr_log [$];
    logic [127:0] wr_data_log [$];
    logic [15:0]  wr_mask_log [$];

    int           resp_left = 0;
    int           resp_sent = 0;
    int           resp_cut = 0;
    int           stall_left = 0;
    logic [27:0]  rd_base;
    logic [27:0]  snap_addr;
    logic [127:0] snap_bits;
    logic [31:0]  rdata;

    cache_assoc dut (
        .clk                (clk),
        .reset              (reset),
        .cpu_req_valid      (cpu_req_valid),
        .cpu_req_ready      (cpu_req_ready),
        .cpu_req_addr       (cpu_req_addr),
        .cpu_req_data       (cpu_req_data),
        .cpu_req_write      (cpu_req_write),
        .cpu_resp_valid     (cpu_resp_valid),
        .cpu_resp_data      (cpu_resp_data),
        .mem_req_valid      (mem_req_valid),
        .mem_req_ready      (mem_req_ready),
        .mem_req_addr       (mem_req_addr),
        .mem_req_rw         (mem_req_rw),
        .mem_req_data_valid (mem_req_data_valid),
        .mem_req_data_ready (mem_req_data_ready),
        .mem_req_data_bits  (mem_req_data_bits),
        .mem_req_data_mask  (mem_req_data_mask),
        .mem_resp_valid     (mem_resp_valid),
        .mem_resp_data      (mem_resp_data)
`ifdef CACHE_PERF_CNT_EN
        ,
        .hit_count          (hit_count),
        .miss_count         (miss_count)
`endif
    );

    always #5 clk = ~clk;

    // Single comparison point: counts, asserts and reports on mismatch.
    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Presents one request at a falling edge once the cache is ready and
    // returns at the next falling edge, i.e. one cycle after the fire.
    task automatic applyStimulus(input logic [29:0] addr, input logic [31:0] data,
                                 input logic [3:0] mask);
        int n = 0;
        while (!cpu_req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ready_before_req", cpu_req_ready, 1'b1);
        cpu_req_valid = 1'b1;
        cpu_req_addr  = addr;
        cpu_req_data  = data;
        cpu_req_write = mask;
        @(negedge clk);
        cpu_req_valid = 1'b0;
        cpu_req_write = 4'b0000;
    endtask

    task automatic waitResp(output logic [31:0] data);
        int n = 0;
        while (!cpu_resp_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("resp_arrived", cpu_resp_valid, 1'b1);
        data = cpu_resp_data;
        @(negedge clk);
    endtask

    task automatic waitReady();
        int n = 0;
        while (!cpu_req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ready_returned", cpu_req_ready, 1'b1);
    endtask

    function automatic logic [127:0] lineBeat(input logic [27:0] maddr);
        logic [127:0] r;
        int unsigned  wa;
        for (int k = 0; k < 4; k++) begin
            wa = {2'b00, maddr, 2'(k)};
            r[32*k +: 32] = mem_store.exists(wa) ? mem_store[wa] : wa;
        end
        return r;
    endfunction

    // Memory responder, working on falling edges: it decides readies,
    // presents refill beats and logs handshakes that complete at the
    // following rising edge. Beat 2 of a write-back can be stalled, during
    // which the held outputs are compared with the first stalled cycle.
    always @(negedge clk) begin
        if (reset) begin
            resp_left          = 0;
            mem_resp_valid     = 1'b0;
            mem_req_data_ready = 1'b1;
        end else begin
            mem_resp_valid = 1'b0;
            if (resp_left > 0 && !(resp_cut != 0 && resp_sent >= 2)) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = lineBeat(rd_base + 28'(4 - resp_left));
                resp_left--;
                resp_sent++;
            end
            mem_req_data_ready = 1'b1;
            if (mem_req_valid && mem_req_rw && mem_req_addr[1:0] == 2'd2 && stall_left > 0) begin
                if (stall_left == 5) begin
                    snap_addr = mem_req_addr;
                    snap_bits = mem_req_data_bits;
                end else begin
                    checkOutput("wb_hold_addr", mem_req_addr, snap_addr);
                    checkOutput("wb_hold_bits", mem_req_data_bits, snap_bits);
                    checkOutput("wb_hold_valid", {mem_req_valid, mem_req_data_valid}, 2'b11);
                end
                mem_req_data_ready = 1'b0;
                stall_left--;
            end
            if (mem_req_valid && mem_req_ready) begin
                if (mem_req_rw && mem_req_data_ready) begin
                    wr_addr_log.push_back(mem_req_addr);
                    wr_data_log.push_back(mem_req_data_bits);
                    wr_mask_log.push_back(mem_req_data_mask);
                    for (int k = 0; k < 4; k++) begin
                        mem_store[{2'b00, mem_req_addr, 2'(k)}] = mem_req_data_bits[32*k +: 32];
                    end
                end else if (!mem_req_rw) begin
                    rd_log.push_back(mem_req_addr);
                    rd_base   = mem_req_addr;
                    resp_left = 4;
                    resp_sent = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset         = 1'b1;
        cpu_req_valid = 1'b0;
        cpu_req_addr  = '0;
        cpu_req_data  = '0;
        cpu_req_write = 4'b0000;
        mem_req_ready = 1'b1;
        mem_resp_data = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_ready", cpu_req_ready, 1'b1);
        checkOutput("rst_resp_valid", cpu_resp_valid, 1'b0);
        checkOutput("rst_resp_data", cpu_resp_data, 32'h0);
        checkOutput("rst_mem_ctrl", {mem_req_valid, mem_req_rw, mem_req_data_valid}, 3'b000);
        checkOutput("rst_mem_addr", mem_req_addr, 28'h0);
        checkOutput("rst_mem_bits", mem_req_data_bits, 128'h0);
        checkOutput("rst_mem_mask", mem_req_data_mask, 16'h0);
        reset = 1'b0;
        @(negedge clk);

        // Cold load: read request for beat address 0x10 issued in cycle 2.
        applyStimulus(30'h40, 32'h0, 4'b0000);
        checkOutput("cold_no_req_c1", mem_req_valid, 1'b0);
        @(negedge clk);
        checkOutput("cold_req_c2", {mem_req_valid, mem_req_rw}, 2'b10);
        checkOutput("cold_req_addr", mem_req_addr, 28'h10);
        waitResp(rdata);
        checkOutput("cold_data", rdata, 32'h40);
        checkOutput("cold_rd_count", rd_log.size(), 1);

        // Hit on the same line: response exactly two cycles after fire.
        applyStimulus(30'h41, 32'h0, 4'b0000);
        checkOutput("hit_c1_no_resp", cpu_resp_valid, 1'b0);
        @(negedge clk);
        checkOutput("hit_c2_resp", cpu_resp_valid, 1'b1);
        checkOutput("hit_data", cpu_resp_data, 32'h41);
        @(negedge clk);
        checkOutput("hit_c3_ready", {cpu_req_ready, cpu_resp_valid}, 2'b10);
        checkOutput("hit_data_held", cpu_resp_data, 32'h41);

        // Store hits: full word, then low half-word merge.
        applyStimulus(30'h42, 32'h1234_5678, 4'b1111);
        checkOutput("st_c1_busy", cpu_req_ready, 1'b0);
        @(negedge clk);
        checkOutput("st_c2_ready", cpu_req_ready, 1'b1);
        applyStimulus(30'h42, 32'hAAAA_BBBB, 4'b0011);
        @(negedge clk);
        applyStimulus(30'h42, 32'h0, 4'b0000);
        waitResp(rdata);
        checkOutput("st_merge_data", rdata, 32'h1234_BBBB);
        checkOutput("st_no_traffic", {rd_log.size(), wr_addr_log.size()}, {32'd1, 32'd0});

        // Three dirty stores to set 8 with tags 0,1,2; the third evicts way 0,
        // with beat 2 of its write-back stalled for five cycles.
        applyStimulus(30'h080, 32'h1111_1111, 4'b1111);
        waitReady();
        applyStimulus(30'h480, 32'h2222_2222, 4'b1111);
        waitReady();
        stall_left = 5;
        applyStimulus(30'h880, 32'h3333_3333, 4'b1111);
        waitReady();
        checkOutput("ev_wr_count", wr_addr_log.size(), 4);
        checkOutput("ev_rd_count", rd_log.size(), 4);
        for (int i = 0; i < 4 && i < wr_addr_log.size(); i++) begin
            checkOutput($sformatf("ev_wr_addr%0d", i), wr_addr_log[i], 28'(32'h20 + i));
            checkOutput($sformatf("ev_wr_mask%0d", i), wr_mask_log[i], 16'hFFFF);
        end
        if (wr_data_log.size() >= 3) begin
            checkOutput("ev_wr_beat0", wr_data_log[0],
                        {32'h83, 32'h82, 32'h81, 32'h1111_1111});
            checkOutput("ev_wr_beat2", wr_data_log[2],
                        {32'h8B, 32'h8A, 32'h89, 32'h88});
        end
        if (rd_log.size() >= 4) begin
            checkOutput("ev_rd_addr", rd_log[3], 28'h220);
        end

        // Reload tag 0: evicts way 1 (tag 1) and refetches the written-back data.
        applyStimulus(30'h080, 32'h0, 4'b0000);
        waitResp(rdata);
        checkOutput("rl_data", rdata, 32'h1111_1111);
        checkOutput("rl_wr_count", wr_addr_log.size(), 8);
        if (wr_addr_log.size() >= 5) begin
            checkOutput("rl_wr_addr", wr_addr_log[4], 28'h120);
            checkOutput("rl_wr_word", wr_data_log[4][31:0], 32'h2222_2222);
        end
`ifdef CACHE_PERF_CNT_EN
        checkOutput("perf_hits", hit_count, 32'd4);
        checkOutput("perf_misses", miss_count, 32'd5);
`endif

        // Reset after two refill beats: back to IDLE, nothing more issued.
        resp_cut  = 1;
        resp_sent = 0;
        applyStimulus(30'h1000, 32'h0, 4'b0000);
        for (int n = 0; n < 100 && resp_sent < 2; n++) begin
            @(negedge clk);
        end
        checkOutput("rst_fill_two_beats", resp_sent, 2);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midrst_ready", cpu_req_ready, 1'b1);
        checkOutput("midrst_outs", {cpu_resp_valid, mem_req_valid, mem_req_data_valid, mem_req_rw},
                    4'b0000);
        checkOutput("midrst_resp_data", cpu_resp_data, 32'h0);
        reset    = 1'b0;
        resp_cut = 0;
        repeat (5) @(negedge clk);
        checkOutput("midrst_quiet", {rd_log.size(), wr_addr_log.size()}, {32'd6, 32'd8});
        applyStimulus(30'h1000, 32'h0, 4'b0000);
        waitResp(rdata);
        checkOutput("refetch_data", rdata, 32'h1000);
        if (rd_log.size() >= 7) begin
            checkOutput("refetch_addr", rd_log[6], 28'h400);
        end
        applyStimulus(30'h41, 32'h0, 4'b0000);
        waitResp(rdata);
        checkOutput("inval_data", rdata, 32'h41);
        checkOutput("inval_rd_count", rd_log.size(), 8);
`ifdef CACHE_PERF_CNT_EN
        checkOutput("perf_after_rst", {hit_count, miss_count}, {32'd0, 32'd2});
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
